// File: rtl/tile_cfg_chain_seg.sv
// tile_cfg_chain_seg
//   One segment of a tile configuration chain. Bits shift from ccff_head into
//   a CFG_BITS+1 shadow register whose top bit is parity. A commit copies the
//   payload into the active register if the running parity is correct. A
//   capture loads the active configuration back into the shadow register so
//   it can be read back through ccff_tail.
//
// Parameters
//   CFG_BITS    payload width (>= 1)
//   ODD_PARITY  required XOR of payload+parity (0 even, 1 odd)
//
// Ports
//   prog_clk       configuration clock, rising edge
//   prog_reset     async active-high reset
//   config_enable  shift one bit per cycle while high
//   ccff_head      serial in
//   cfg_commit     request shadow -> active transfer
//   cfg_capture    request active -> shadow readback load
//   ccff_tail      serial out (top shadow bit)
//   cfg_active     active configuration to the fabric
//   cfg_valid      at least one good commit since reset
//   cfg_busy       state is LOAD or APPLY
//   cfg_err        sticky parity failure
module tile_cfg_chain_seg #(
  parameter int CFG_BITS   = 64,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                config_enable,
  input  logic                ccff_head,
  input  logic                cfg_commit,
  input  logic                cfg_capture,
  output logic                ccff_tail,
  output logic [CFG_BITS-1:0] cfg_active,
  output logic                cfg_valid,
  output logic                cfg_busy,
  output logic                cfg_err
);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, APPLY} state_e;

  state_e              state_q, state_d;
  logic [CFG_BITS:0]   sr_q, sr_d;
  logic                p_q, p_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                do_cap;
  logic                par_ok;

  assign par_ok = (p_q == ODD_PARITY);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    valid_d  = valid_q;
    err_d    = err_q;
    do_cap   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (config_enable)    state_d = LOAD;
        else if (cfg_capture) do_cap  = 1'b1;
      end
      LOAD: begin
        if (!config_enable) state_d = ARMED;
      end
      ARMED: begin
        // Enable beats commit beats capture.
        if (config_enable) begin
          state_d = LOAD;
        end else if (cfg_commit) begin
          if (par_ok) begin
            state_d  = APPLY;
            active_d = sr_q[CFG_BITS-1:0];
            valid_d  = 1'b1;
            err_d    = 1'b0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (cfg_capture) begin
          do_cap  = 1'b1;
          state_d = IDLE;
        end
      end
      APPLY: begin
        state_d = config_enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shifting is allowed in every state; capture only fires with enable low.
    sr_d = sr_q;
    p_d  = p_q;
    if (config_enable) begin
      sr_d = {sr_q[CFG_BITS-1:0], ccff_head};
      // Running parity: add the incoming bit, drop the outgoing one.
      p_d  = p_q ^ ccff_head ^ sr_q[CFG_BITS];
    end else if (do_cap) begin
      sr_d = {(^active_q) ^ ODD_PARITY, active_q};
      p_d  = ODD_PARITY;
    end

    busy_d = (state_d == LOAD) || (state_d == APPLY);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      p_q      <= 1'b0;
      active_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      p_q      <= p_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ccff_tail  = sr_q[CFG_BITS];
  assign cfg_active = active_q;
  assign cfg_valid  = valid_q;
  assign cfg_err    = err_q;
  assign cfg_busy   = busy_q;

endmodule

// File: tb/tb_tile_cfg_chain_seg.sv
// Directed bench for tile_cfg_chain_seg (CFG_BITS=8, even parity). Instance A
// is the unit under test; instance B is chained from A's tail to check that a
// readback stream commits cleanly downstream.
module tb_tile_cfg_chain_seg;
  logic       gclk = 1'b0;
  logic       rst;
  logic       en_a, head_a, commit_a, cap_a;
  logic       tail_a, valid_a, busy_a, err_a;
  logic [7:0] act_a;
  logic       en_b, commit_b;
  logic       tail_b, valid_b, busy_b, err_b;
  logic [7:0] act_b;

  int total = 0;
  int bad   = 0;

  always #5 gclk = ~gclk;

  tile_cfg_chain_seg #(.CFG_BITS(8), .ODD_PARITY(1'b0)) u_a (
    .prog_clk(gclk), .prog_reset(rst), .config_enable(en_a), .ccff_head(head_a),
    .cfg_commit(commit_a), .cfg_capture(cap_a), .ccff_tail(tail_a),
    .cfg_active(act_a), .cfg_valid(valid_a), .cfg_busy(busy_a), .cfg_err(err_a));

  tile_cfg_chain_seg #(.CFG_BITS(8), .ODD_PARITY(1'b0)) u_b (
    .prog_clk(gclk), .prog_reset(rst), .config_enable(en_b), .ccff_head(tail_a),
    .cfg_commit(commit_b), .cfg_capture(1'b0), .ccff_tail(tail_b),
    .cfg_active(act_b), .cfg_valid(valid_b), .cfg_busy(busy_b), .cfg_err(err_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // Shift {parity, payload} MSB-first, then drop enable for one edge (-> ARMED).
  task automatic load_a(input logic [8:0] v);
    for (int i = 8; i >= 0; i--) begin
      en_a = 1'b1; head_a = v[i];
      step();
    end
    en_a = 1'b0; head_a = 1'b0;
    step();
  endtask

  task automatic pulse_commit_a();
    commit_a = 1'b1;
    step();
    commit_a = 1'b0;
  endtask

  initial begin
    logic [19:0] pat;
    rst = 1'b1; en_a = 0; head_a = 0; commit_a = 0; cap_a = 0; en_b = 0; commit_b = 0;
    #12;
    chk("rst_active", act_a, 8'h00);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_tail", tail_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    rst = 1'b0;
    step();

    // Good commit of 0xA5 (four ones, parity 0).
    load_a({1'b0, 8'hA5});
    chk("armed_busy", busy_a, 1'b0);
    pulse_commit_a();
    chk("good_active", act_a, 8'hA5);
    chk("good_valid", valid_a, 1'b1);
    chk("good_err", err_a, 1'b0);
    chk("apply_busy", busy_a, 1'b1);
    step();
    chk("post_apply_busy", busy_a, 1'b0);

    // Bad parity: active holds, error sticks through a following load.
    load_a({1'b1, 8'hA5});
    pulse_commit_a();
    chk("bad_err", err_a, 1'b1);
    chk("bad_active", act_a, 8'hA5);
    chk("bad_busy", busy_a, 1'b0);
    load_a({1'b0, 8'h3C});
    chk("err_sticky", err_a, 1'b1);
    pulse_commit_a();
    chk("recov_err", err_a, 1'b0);
    chk("recov_active", act_a, 8'h3C);
    step();

    // Pass-through: bit sent on edge j reaches the tail after edge j+8.
    pat = 20'hB4E29;
    for (int j = 0; j < 20; j++) begin
      en_a = 1'b1; head_a = pat[19-j];
      step();
      if (j >= 8) chk($sformatf("pass_%0d", j), tail_a, pat[19-(j-8)]);
    end
    chk("pass_active", act_a, 8'h3C);
    en_a = 1'b0; head_a = 1'b0;
    step();                       // LOAD -> ARMED
    cap_a = 1'b1; step(); cap_a = 1'b0;   // capture from ARMED -> IDLE
    chk("cap_armed_busy", busy_a, 1'b0);

    // Readback: capture in IDLE, stream 0 then 0x3C MSB-first into B.
    cap_a = 1'b1; step(); cap_a = 1'b0;
    chk("cap_active", act_a, 8'h3C);
    begin
      logic [8:0] rb;
      rb = {1'b0, 8'h3C};
      for (int i = 8; i >= 0; i--) begin
        chk($sformatf("rb_%0d", i), tail_a, rb[i]);
        en_a = 1'b1; en_b = 1'b1;
        step();
      end
    end
    en_a = 1'b0; en_b = 1'b0;
    step();
    commit_b = 1'b1; step(); commit_b = 1'b0;
    chk("b_active", act_b, 8'h3C);
    chk("b_err", err_b, 1'b0);
    step();

    // Commit held through LOAD is ignored; commit+capture in ARMED -> commit only.
    commit_a = 1'b1;
    load_a({1'b1, 8'h07});
    chk("load_commit_ign", act_a, 8'h3C);
    cap_a = 1'b1;
    step();
    commit_a = 1'b0; cap_a = 1'b0;
    chk("prio_active", act_a, 8'h07);
    chk("prio_no_reload", tail_a, 1'b1);
    chk("prio_busy", busy_a, 1'b1);
    step();

    // Enable rising in ARMED wins over commit.
    load_a({1'b0, 8'h5A});
    en_a = 1'b1; commit_a = 1'b1;
    step();
    en_a = 1'b0; commit_a = 1'b0;
    chk("en_prio_active", act_a, 8'h07);
    chk("en_prio_busy", busy_a, 1'b1);
    step();
    cap_a = 1'b1; step(); cap_a = 1'b0;
    chk("cap_par_07", tail_a, 1'b1);

    // Reset mid-shift: outputs clear without a clock edge.
    for (int i = 0; i < 4; i++) begin
      en_a = 1'b1; head_a = 1'b1;
      step();
    end
    rst = 1'b1; en_a = 1'b0; head_a = 1'b0;
    #1;
    chk("rs_active", act_a, 8'h00);
    chk("rs_valid", valid_a, 1'b0);
    chk("rs_tail", tail_a, 1'b0);
    chk("rs_busy", busy_a, 1'b0);
    rst = 1'b0;
    step();
    load_a({1'b0, 8'hA5});
    pulse_commit_a();
    chk("rs_fresh_active", act_a, 8'hA5);
    chk("rs_fresh_valid", valid_a, 1'b1);

    // Reset during APPLY.
    load_a({1'b0, 8'h3C});
    pulse_commit_a();
    chk("ra_in_apply", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("ra_active", act_a, 8'h00);
    chk("ra_valid", valid_a, 1'b0);
    chk("ra_busy", busy_a, 1'b0);
    rst = 1'b0;
    step();
    load_a({1'b0, 8'h81});
    pulse_commit_a();
    chk("ra_fresh_active", act_a, 8'h81);
    chk("ra_fresh_valid", valid_a, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_cfg_chain_seg.md
# tile_cfg_chain_seg

Parametrised configuration-chain segment for a routing tile. It is the next generation of the per-tile `ccff_head`→`ccff_tail` chain. Each segment adds shadowed (double-buffered) configuration, a parity-protected commit, and capture/readback of the active configuration. One instance sits in every tile. Its `cfg_active` bus drives the switch-block and connection-block mux selects.

## Interface
Parameters:
- `CFG_BITS`, default 64: payload bits held by this segment, minimum 1.
- `ODD_PARITY`, default 0: required XOR over the payload plus parity bit (0 = even, 1 = odd).

Ports:
- `prog_clk`, input, 1: configuration clock. All state is on its rising edge.
- `prog_reset`, input, 1: asynchronous, active-high reset.
- `config_enable`, input, 1: shift enable. When 1, the chain shifts one bit per cycle.
- `ccff_head`, input, 1: serial chain input.
- `cfg_commit`, input, 1: request to transfer the shift register into the active register.
- `cfg_capture`, input, 1: request to load the active register back into the shift register for readback.
- `ccff_tail`, output, 1: serial chain output, equal to `SR[CFG_BITS]`.
- `cfg_active`, output, `CFG_BITS`: active configuration driven to the fabric.
- `cfg_valid`, output, 1: set once at least one commit has succeeded since reset.
- `cfg_busy`, output, 1: 1 in state LOAD or APPLY.
- `cfg_err`, output, 1: sticky parity-failure flag.

## Operation
Shift register and parity:
- The shift register `SR` is `CFG_BITS+1` bits. `SR[0]` is nearest the head. `SR[CFG_BITS]` is the parity bit, nearest the tail. The payload is `SR[CFG_BITS-1:0]`.
- On every edge with `config_enable`=1, in any state: `SR <= {SR[CFG_BITS-1:0], ccff_head}`.
- A running-parity register `p` holds the XOR of all `SR` bits. It is updated incrementally on each shift: `p <= p ^ ccff_head ^ SR[CFG_BITS]`. No full reduction is performed per shift.
- Parity is OK when `p == ODD_PARITY`.

State machine (IDLE, LOAD, ARMED, APPLY):
- **IDLE.** `config_enable`=1 → LOAD. `cfg_capture`=1 with `config_enable`=0 → perform capture, stay in IDLE. `cfg_commit` is ignored.
- **LOAD.** `config_enable`=0 → ARMED. `cfg_commit` and `cfg_capture` are ignored.
- **ARMED.** Rules in priority order:
  - `config_enable`=1 → LOAD. The pending commit is discarded.
  - `cfg_commit`=1 with parity OK → APPLY. On the same edge: `cfg_active <= payload`, `cfg_valid <= 1`, `cfg_err <= 0`.
  - `cfg_commit`=1 with parity bad → IDLE. `cfg_err <= 1`; `cfg_active` is unchanged.
  - `cfg_capture`=1 → perform capture, go to IDLE.
- **APPLY.** Lasts one cycle. Goes to LOAD if `config_enable`=1, otherwise IDLE.

Capture:
- `SR[CFG_BITS-1:0] <= cfg_active`.
- `SR[CFG_BITS] <= ^cfg_active ^ ODD_PARITY`.
- `p <= ODD_PARITY`.

Boundary rules:
- `cfg_commit` and `cfg_capture` in the same cycle: commit wins, capture is dropped.
- `cfg_err` clears only on reset or on a successful commit.
- Bits that pass through to downstream segments are not counted. The controller is responsible for framing; parity is the only integrity check.

Reset (asynchronous):
- `SR`=0, `p`=0, state = IDLE.
- Outputs: `cfg_active`=0, `cfg_valid`=0, `cfg_err`=0, `cfg_busy`=0, `ccff_tail`=0.
- Reset asserted mid-shift or mid-APPLY aborts immediately. No partial commit survives.

## Timing
- Head-to-tail latency: `CFG_BITS+1` enabled cycles. A bit sampled on edge k appears on `ccff_tail` after edge k+`CFG_BITS`.
- `ccff_tail`, `cfg_active`, `cfg_valid`, `cfg_err` and `cfg_busy` are all registered. There is no combinational path from inputs to outputs.
- Commit: `cfg_commit` sampled at edge k → `cfg_active` new after edge k. APPLY occupies cycle k+1. `cfg_commit` is accepted at the earliest one cycle after `config_enable` falls.
- Capture: `cfg_capture` sampled at edge k → `ccff_tail` shows the captured parity bit after edge k. The payload MSB appears after the first enabled shift.
- `cfg_active` changes only on a successful commit edge. It is stable through shifting, capture and failed commits.

## Test plan
- **Good commit.** `CFG_BITS`=8, even parity. Shift 9 bits: parity 0 then 0xA5 MSB-first. Drop enable, pulse `cfg_commit`. Expect `cfg_active`=0xA5, `cfg_valid`=1, `cfg_err`=0 one edge later, and `cfg_busy`=1 for exactly the APPLY cycle.
- **Bad parity.** Same sequence with parity bit 1. Expect `cfg_err`=1, `cfg_active` holding its prior value (0xA5 or 0), state IDLE. A following good load and commit of 0x3C clears `cfg_err` and gives `cfg_active`=0x3C.
- **Pass-through.** Hold `config_enable`=1 and drive a 20-bit pattern into `ccff_head`. `ccff_tail` reproduces the pattern delayed by exactly 9 cycles. `cfg_active` is unchanged.
- **Readback.** With `cfg_active`=0x3C, pulse `cfg_capture` in IDLE, then shift 9 cycles. The tail emits 0, then 0x3C MSB-first. Committing that stream into a second instance yields 0x3C.
- **Priority and ignore.** `cfg_commit` during LOAD → no change. `cfg_commit` and `cfg_capture` in the same ARMED cycle → commit only, `SR` not reloaded. `config_enable` rising in ARMED before commit → back to LOAD, no commit.
- **Reset mid-operation.** Assert `prog_reset` midway through the 9-bit shift and during APPLY. All outputs are 0 immediately, with no clock needed. Expect `cfg_valid`=0, and a fresh load/commit succeeds.
